// File: rtl/lcd_pattern_pkg.sv
// Shared definitions for the LCD test-pattern sequencer.
//   PAT_*           3-bit pattern codes as shown on pattern_idx
//   C_*             RGB565 colour constants {r[4:0],g[5:0],b[4:0]}
//   db_state_t      key debouncer state
//   step_state_t    pattern-step state (idle / step pending until next frame)
//   band_edge()     first column of bit-walk band k for a given active width
package lcd_pattern_pkg;

    localparam logic [2:0] PAT_BITWALK = 3'd0;
    localparam logic [2:0] PAT_RED     = 3'd1;
    localparam logic [2:0] PAT_GREEN   = 3'd2;
    localparam logic [2:0] PAT_BLUE    = 3'd3;
    localparam logic [2:0] PAT_WHITE   = 3'd4;
    localparam logic [2:0] PAT_BLACK   = 3'd5;
    localparam logic [2:0] PAT_GRID    = 3'd6;
    localparam logic [2:0] PAT_RAMP    = 3'd7;

    localparam logic [15:0] C_RED   = 16'hF800;
    localparam logic [15:0] C_GREEN = 16'h07E0;
    localparam logic [15:0] C_BLUE  = 16'h001F;
    localparam logic [15:0] C_WHITE = 16'hFFFF;
    localparam logic [15:0] C_BLACK = 16'h0000;

    typedef enum logic {DB_ARMED, DB_HELD} db_state_t;
    typedef enum logic {ST_IDLE, ST_PEND} step_state_t;

    // Band k spans [band_edge(k), band_edge(k+1)); only ever called with
    // elaboration-time constants, so it folds to a fixed comparator threshold.
    function automatic int unsigned band_edge(input int unsigned k, input int unsigned h_active);
        return (h_active * k) / 16;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Key synchroniser and debouncer.
//   clk, rst_n   clock, asynchronous active-low reset
//   key_n        raw active-low key, asynchronous to clk
//   key_step     one-cycle pulse when a press is accepted
// A press needs DEBOUNCE_CYC consecutive low samples; afterwards the key must
// read high for DEBOUNCE_CYC consecutive samples before the next press can be
// accepted, so a held key yields exactly one pulse.
module key_debounce
    import lcd_pattern_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 660000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_step
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic             key_meta;
    logic             key_sync;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             step_nxt;
    logic             target_lvl;

    // Synchroniser resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_meta <= 1'b1;
            key_sync <= 1'b1;
        end else begin
            key_meta <= key_n;
            key_sync <= key_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= DB_ARMED;
            cnt      <= '0;
            key_step <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            key_step <= step_nxt;
        end
    end

    // The counter measures a run of the level that would flip the state:
    // low while armed, high while held. Any other sample restarts the run.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = '0;
        step_nxt   = 1'b0;
        target_lvl = (state == DB_HELD);
        if (key_sync == target_lvl) begin
            if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                state_nxt = (state == DB_ARMED) ? DB_HELD : DB_ARMED;
                step_nxt  = (state == DB_ARMED);
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/lcd_pattern_sequencer.sv
// Test-pattern scheduler between the LCD timing generator and the LCD pins.
//   rgb_clk, rgb_rst_n        pixel clock, asynchronous active-low reset
//   key_n                     user key (active low, asynchronous)
//   auto_en                   auto-advance every FRAMES_PER_PAT frames
//   in_hs/in_vs/in_de         timing-generator syncs and data enable
//   in_x/in_y                 active-area column / row
//   out_hs/out_vs/out_de      inputs delayed one cycle
//   out_rgb                   RGB565 pixel aligned with out_de (0 when out_de=0)
//   pattern_idx               pattern currently displayed
// The pattern only changes at a frame boundary (in_vs entering VS_POL).
module lcd_pattern_sequencer
    import lcd_pattern_pkg::*;
#(
    parameter int   H_ACTIVE       = 800,
    parameter int   V_ACTIVE       = 480,
    parameter int   FRAMES_PER_PAT = 120,
    parameter int   DEBOUNCE_CYC   = 660000,
    parameter logic VS_POL         = 1'b0
) (
    input  logic        rgb_clk,
    input  logic        rgb_rst_n,
    input  logic        key_n,
    input  logic        auto_en,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic        in_de,
    input  logic [9:0]  in_x,
    input  logic [9:0]  in_y,
    output logic        out_hs,
    output logic        out_vs,
    output logic        out_de,
    output logic [15:0] out_rgb,
    output logic [2:0]  pattern_idx
);

    localparam int CNT_W = (FRAMES_PER_PAT > 1) ? $clog2(FRAMES_PER_PAT) : 1;

    logic             key_step;
    logic             vs_prev;
    logic             fb;
    logic             auto_step;
    step_state_t      st;
    step_state_t      st_nxt;
    logic [2:0]       pat_nxt;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [15:1]      band_ge;
    logic [3:0]       band;
    logic [15:0]      pix;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key (
        .clk     (rgb_clk),
        .rst_n   (rgb_rst_n),
        .key_n   (key_n),
        .key_step(key_step)
    );

    // vs_prev resets to the active level so an already-active vsync at reset
    // release is not mistaken for a new frame.
    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) vs_prev <= VS_POL;
        else            vs_prev <= in_vs;
    end

    assign fb        = (in_vs == VS_POL) && (vs_prev != VS_POL);
    assign auto_step = auto_en && (frame_cnt == CNT_W'(FRAMES_PER_PAT - 1));

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            st          <= ST_IDLE;
            pattern_idx <= PAT_BITWALK;
            frame_cnt   <= '0;
        end else begin
            st          <= st_nxt;
            pattern_idx <= pat_nxt;
            frame_cnt   <= cnt_nxt;
        end
    end

    // Key and auto requests within one frame merge into a single increment;
    // a key pulse coinciding with fb is consumed by that same fb.
    always_comb begin
        st_nxt  = st;
        pat_nxt = pattern_idx;
        cnt_nxt = frame_cnt;
        if (fb) begin
            if (st == ST_PEND || key_step || auto_step) begin
                pat_nxt = pattern_idx + 3'd1;
                st_nxt  = ST_IDLE;
                cnt_nxt = '0;
            end else if (auto_en) begin
                cnt_nxt = frame_cnt + 1'b1;
            end
        end else if (key_step) begin
            st_nxt = ST_PEND;
        end
        if (!auto_en) cnt_nxt = '0;
    end

    // Bit-walk band: thermometer of constant thresholds, then pick the highest set.
    for (genvar k = 1; k < 16; k++) begin : g_band
        assign band_ge[k] = (32'(in_x) >= band_edge(k, H_ACTIVE));
    end

    always_comb begin
        band = '0;
        for (int k = 1; k < 16; k++) begin
            if (band_ge[k]) band = 4'(k);
        end
    end

    always_comb begin
        pix = C_BLACK;
        case (pattern_idx)
            PAT_BITWALK: pix = 16'h8000 >> band;
            PAT_RED:     pix = C_RED;
            PAT_GREEN:   pix = C_GREEN;
            PAT_BLUE:    pix = C_BLUE;
            PAT_WHITE:   pix = C_WHITE;
            PAT_BLACK:   pix = C_BLACK;
            PAT_GRID:    pix = ((in_x[4:0] == 5'd0) || (in_y[4:0] == 5'd0) ||
                                (in_x == 10'(H_ACTIVE - 1)) || (in_y == 10'(V_ACTIVE - 1)))
                               ? C_WHITE : C_BLACK;
            PAT_RAMP:    pix = {in_x[9:5], in_x[9:5], in_x[4], in_x[9:5]};
            default:     pix = C_BLACK;
        endcase
    end

    always_ff @(posedge rgb_clk or negedge rgb_rst_n) begin
        if (!rgb_rst_n) begin
            out_hs  <= 1'b0;
            out_vs  <= 1'b0;
            out_de  <= 1'b0;
            out_rgb <= 16'h0000;
        end else begin
            out_hs  <= in_hs;
            out_vs  <= in_vs;
            out_de  <= in_de;
            out_rgb <= in_de ? pix : 16'h0000;
        end
    end

endmodule

// File: tb/tb_lcd_pattern_sequencer.sv
module tb_lcd_pattern_sequencer;

    localparam int   H  = 800;
    localparam int   V  = 480;
    localparam int   F  = 3;
    localparam int   D  = 8;
    localparam logic VS_POL = 1'b0;

    logic        rgb_clk;
    logic        rgb_rst_n;
    logic        key_n;
    logic        auto_en;
    logic        in_hs;
    logic        in_vs;
    logic        in_de;
    logic [9:0]  in_x;
    logic [9:0]  in_y;
    logic        out_hs;
    logic        out_vs;
    logic        out_de;
    logic [15:0] out_rgb;
    logic [2:0]  pattern_idx;

    lcd_pattern_sequencer #(
        .H_ACTIVE(H), .V_ACTIVE(V), .FRAMES_PER_PAT(F), .DEBOUNCE_CYC(D), .VS_POL(VS_POL)
    ) dut (
        .rgb_clk(rgb_clk), .rgb_rst_n(rgb_rst_n), .key_n(key_n), .auto_en(auto_en),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .in_x(in_x), .in_y(in_y),
        .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de), .out_rgb(out_rgb),
        .pattern_idx(pattern_idx)
    );

    initial rgb_clk = 1'b0;
    always #5 rgb_clk = ~rgb_clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: displayed pattern, frames counted toward the
    // auto step, pending key request, previous vsync, key run lengths.
    int m_pat;
    int m_cnt;
    bit m_pend;
    bit m_vs_prev;
    int run_lo;
    int run_hi;
    bit armed;
    bit ks_dly [3];   // accepted presses reach the step logic 3 clocks later

    typedef struct {
        bit          de;
        int          x;
        logic [15:0] exp;
    } vec_t;
    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_pix(input int p, input int x, input int y);
        int r;
        int g;
        case (p)
            0: return 16'h8000 >> ((16 * x + 15) / H);
            1: return 16'hF800;
            2: return 16'h07E0;
            3: return 16'h001F;
            4: return 16'hFFFF;
            5: return 16'h0000;
            6: return ((x % 32 == 0) || (y % 32 == 0) || (x == H - 1) || (y == V - 1)) ? 16'hFFFF : 16'h0000;
            default: begin
                r = x / 32;
                g = x / 16;
                return 16'((r << 11) | (g << 5) | r);
            end
        endcase
    endfunction

    task automatic model_reset();
        m_pat = 0; m_cnt = 0; m_pend = 0; m_vs_prev = VS_POL;
        run_lo = 0; run_hi = 0; armed = 1;
        ks_dly[0] = 0; ks_dly[1] = 0; ks_dly[2] = 0;
    endtask

    // One clock: predict from the inputs being sampled, advance the model,
    // then compare every output just after the edge.
    task automatic tick();
        logic        e_hs, e_vs, e_de;
        logic [15:0] e_rgb;
        bit          acc, ks_now, fb, auto_step;
        e_hs  = in_hs;
        e_vs  = in_vs;
        e_de  = in_de;
        e_rgb = in_de ? m_pix(m_pat, int'(in_x), int'(in_y)) : 16'h0000;
        acc = 0;
        if (key_n == 1'b0) begin
            run_lo++; run_hi = 0;
            if (armed && run_lo == D) begin acc = 1; armed = 0; end
        end else begin
            run_hi++; run_lo = 0;
            if (!armed && run_hi == D) armed = 1;
        end
        ks_now = ks_dly[2];
        ks_dly[2] = ks_dly[1];
        ks_dly[1] = ks_dly[0];
        ks_dly[0] = acc;
        fb = (in_vs == VS_POL) && (m_vs_prev != VS_POL);
        m_vs_prev = in_vs;
        if (fb) begin
            auto_step = auto_en && (m_cnt == F - 1);
            if (m_pend || ks_now || auto_step) begin
                m_pat = (m_pat + 1) % 8; m_pend = 0; m_cnt = 0;
            end else if (auto_en) begin
                m_cnt++;
            end
        end else if (ks_now) begin
            m_pend = 1;
        end
        if (!auto_en) m_cnt = 0;
        @(posedge rgb_clk);
        #1;
        check("hs_dly", 32'(out_hs), 32'(e_hs));
        check("vs_dly", 32'(out_vs), 32'(e_vs));
        check("de_dly", 32'(out_de), 32'(e_de));
        check("rgb", 32'(out_rgb), 32'(e_rgb));
        check("pattern_idx", 32'(pattern_idx), 32'(m_pat));
    endtask

    task automatic idle(input int n);
        in_hs = 0; in_de = 0;
        repeat (n) tick();
    endtask

    task automatic vs_pulse();
        in_hs = 0; in_de = 0;
        in_vs = VS_POL;  tick(); tick();
        in_vs = !VS_POL; tick();
    endtask

    task automatic line(input int y);
        in_hs = 1; in_de = 0; tick();
        in_hs = 0;
        for (int n = 0; n < 6; n++) begin
            in_de = 1;
            in_x  = 10'($urandom_range(0, H - 1));
            in_y  = 10'(y);
            tick();
        end
        in_de = 0; tick();
    endtask

    task automatic frame();
        vs_pulse();
        for (int y = 0; y < 3; y++) line(y);
    endtask

    task automatic press(input int n);
        key_n = 0;
        idle(n);
        key_n = 1;
    endtask

    initial begin
        rgb_rst_n = 0; key_n = 1; auto_en = 0;
        in_hs = 0; in_vs = !VS_POL; in_de = 0; in_x = 0; in_y = 0;
        model_reset();
        repeat (3) @(posedge rgb_clk);
        #1;
        check("reset_rgb", 32'(out_rgb), 32'h0);
        check("reset_de", 32'(out_de), 32'h0);
        check("reset_pat", 32'(pattern_idx), 32'h0);
        rgb_rst_n = 1;
        idle(4);

        // Bit-walk band edges, pattern 0
        vecs[0] = '{1'b1, 0,   16'h8000};
        vecs[1] = '{1'b1, 49,  16'h8000};
        vecs[2] = '{1'b1, 50,  16'h4000};
        vecs[3] = '{1'b1, 99,  16'h4000};
        vecs[4] = '{1'b1, 100, 16'h2000};
        vecs[5] = '{1'b1, 400, 16'h0080};
        vecs[6] = '{1'b1, 749, 16'h0002};
        vecs[7] = '{1'b1, 750, 16'h0001};
        vecs[8] = '{1'b1, 799, 16'h0001};
        vecs[9] = '{1'b0, 50,  16'h0000};
        for (int i = 0; i < 10; i++) begin
            in_de = vecs[i].de;
            in_x  = 10'(vecs[i].x);
            in_y  = 10'd5;
            tick();
            check("bitwalk_tbl", 32'(out_rgb), 32'(vecs[i].exp));
        end

        // Asynchronous reset mid-frame with de active
        in_hs = 1; in_de = 1; in_x = 10'd100; tick();
        #3 rgb_rst_n = 0;
        #1;
        check("async_rst_rgb", 32'(out_rgb), 32'h0);
        check("async_rst_de", 32'(out_de), 32'h0);
        check("async_rst_hs", 32'(out_hs), 32'h0);
        model_reset();
        @(posedge rgb_clk);
        #1 rgb_rst_n = 1;
        in_hs = 0; in_de = 1; in_x = 10'd0; in_y = 10'd0;
        tick();
        check("first_pix", 32'(out_rgb), 32'h8000);
        check("first_pat", 32'(pattern_idx), 32'h0);
        idle(3);

        // Short glitch: no step
        frame();
        press(5);
        idle(10);
        frame();
        frame();
        check("glitch_pat", 32'(pattern_idx), 32'd0);

        // Mid-frame press: one step, only at the next fb
        press(20);
        idle(12);
        line(1);
        check("press_no_early", 32'(pattern_idx), 32'd0);
        vs_pulse();
        check("press_step", 32'(pattern_idx), 32'd1);
        frame();
        check("press_once", 32'(pattern_idx), 32'd1);

        // Key held over 4 frames: single step
        key_n = 0;
        repeat (4) frame();
        key_n = 1;
        idle(D + 4);
        frame();
        check("hold_single", 32'(pattern_idx), 32'd2);

        // Auto advance every F frames
        auto_en = 1;
        idle(2);
        frame(); frame();
        check("auto_fb2", 32'(pattern_idx), 32'd2);
        frame();
        check("auto_fb3", 32'(pattern_idx), 32'd3);
        repeat (3) frame();
        check("auto_fb6", 32'(pattern_idx), 32'd4);
        repeat (18) frame();
        check("auto_wrap24", 32'(pattern_idx), 32'd2);

        // Key press in the frame where the auto step is due
        frame(); frame();
        check("coll_pre", 32'(pattern_idx), 32'd2);
        press(20);
        idle(D + 4);
        frame();
        check("coll_step", 32'(pattern_idx), 32'd3);
        frame(); frame();
        check("coll_cnt_restart", 32'(pattern_idx), 32'd3);
        frame();
        check("coll_next_auto", 32'(pattern_idx), 32'd4);

        // Random timing, keys and auto_en against the model
        for (int i = 0; i < 4000; i++) begin
            in_hs = 1'($urandom);
            if ($urandom_range(0, 15) == 0) in_vs = ~in_vs;
            in_de = 1'($urandom);
            in_x  = 10'($urandom_range(0, H - 1));
            in_y  = 10'($urandom_range(0, V - 1));
            if ($urandom_range(0, 15) == 0) key_n = ~key_n;
            if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
